// File: rtl/mem_port_arbiter.sv
// Memory bus port arbiter: shares one bus port between instruction fetch, load and store.
// Optional fetch anti-starvation (and its STARVE_LIMIT parameter) is enabled by defining MEMARB_STARVE_EN.
module mem_port_arbiter #(
    parameter int LINE_BEATS = 8
`ifdef MEMARB_STARVE_EN
    ,
    parameter int STARVE_LIMIT = 4
`endif
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          ifetch_req,
    input  logic [63:0]                   ifetch_addr,
    input  logic                          load_req,
    input  logic [63:0]                   load_addr,
    input  logic                          store_req,
    input  logic [63:0]                   store_addr,
    input  logic [63:0]                   store_wdata,
    output logic                          store_wbeat_rdy,
    output logic [2:0]                    grant,
    output logic [63:0]                   rdata,
    output logic                          rdata_valid,
    output logic [$clog2(LINE_BEATS)-1:0] rbeat_idx,
    output logic                          ifetch_done,
    output logic                          load_done,
    output logic                          store_done,
    output logic                          bus_reqcyc,
    output logic [63:0]                   bus_req_addr,
    output logic                          bus_req_write,
    input  logic                          bus_reqack,
    output logic                          bus_wvalid,
    output logic [63:0]                   bus_wdata,
    input  logic                          bus_respcyc,
    input  logic [63:0]                   bus_resp,
    output logic                          bus_respack
);

    localparam int BW = $clog2(LINE_BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_BEATS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WDATA = 3'd2,
        ST_RESP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    grant_q, grant_d;
    logic [63:0]   addr_q, addr_d;
    logic          write_q, write_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          fetch_prio_s;
    logic [2:0]    win_s;

`ifdef MEMARB_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_q, starve_d;

    assign fetch_prio_s = (starve_q == STARVE_MAX);

    // Count data grants taken while fetch waits; saturates so fetch keeps priority until served.
    always_comb begin
        starve_d = starve_q;
        if (state_q == ST_IDLE) begin
            if (!ifetch_req || win_s[0]) begin
                starve_d = '0;
            end else if ((win_s[2] || win_s[1]) && !fetch_prio_s) begin
                starve_d = starve_q + SW'(1);
            end else begin
                starve_d = starve_q;
            end
        end else begin
            starve_d = starve_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign fetch_prio_s = 1'b0;
`endif

    // Pick the winning requester, store > load > fetch unless fetch has been starved.
    always_comb begin
        win_s = 3'b000;
        if (fetch_prio_s && ifetch_req) begin
            win_s = 3'b001;
        end else if (store_req) begin
            win_s = 3'b100;
        end else if (load_req) begin
            win_s = 3'b010;
        end else if (ifetch_req) begin
            win_s = 3'b001;
        end else begin
            win_s = 3'b000;
        end
    end

    // Transfer FSM next state, latched request fields and bus/requester outputs.
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        addr_d          = addr_q;
        write_d         = write_q;
        beat_d          = beat_q;
        store_wbeat_rdy = 1'b0;
        rdata           = 64'h0;
        rdata_valid     = 1'b0;
        rbeat_idx       = '0;
        ifetch_done     = 1'b0;
        load_done       = 1'b0;
        store_done      = 1'b0;
        bus_reqcyc      = 1'b0;
        bus_req_addr    = 64'h0;
        bus_req_write   = 1'b0;
        bus_wvalid      = 1'b0;
        bus_wdata       = 64'h0;
        bus_respack     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_s != 3'b000) begin
                    grant_d = win_s;
                    write_d = win_s[2];
                    beat_d  = '0;
                    state_d = ST_REQ;
                    case (win_s)
                        3'b100:  addr_d = store_addr;
                        3'b010:  addr_d = load_addr;
                        3'b001:  addr_d = ifetch_addr;
                        default: addr_d = 64'h0;
                    endcase
                end else begin
                    grant_d = 3'b000;
                end
            end
            ST_REQ: begin
                bus_reqcyc    = 1'b1;
                bus_req_addr  = addr_q;
                bus_req_write = write_q;
                if (bus_reqack) begin
                    beat_d  = '0;
                    state_d = write_q ? ST_WDATA : ST_RESP;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WDATA: begin
                // The bus never stalls write beats, so one beat leaves every cycle.
                bus_wvalid      = 1'b1;
                store_wbeat_rdy = 1'b1;
                bus_wdata       = store_wdata;
                beat_d          = beat_q + BW'(1);
                if (beat_q == LAST_BEAT) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WDATA;
                end
            end
            ST_RESP: begin
                bus_respack = bus_respcyc;
                if (bus_respcyc) begin
                    rdata       = bus_resp;
                    rdata_valid = 1'b1;
                    rbeat_idx   = beat_q;
                    beat_d      = beat_q + BW'(1);
                    state_d     = (beat_q == LAST_BEAT) ? ST_DONE : ST_RESP;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_DONE: begin
                store_done  = grant_q[2];
                load_done   = grant_q[1];
                ifetch_done = grant_q[0];
                grant_d     = 3'b000;
                state_d     = ST_IDLE;
            end
            default: begin
                grant_d = 3'b000;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and transfer context registers; reset drops any in-flight transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= 3'b000;
            addr_q  <= 64'h0;
            write_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            beat_q  <= beat_d;
        end
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: bus/requester driver plus a queue-based scoreboard.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ifetch_req, load_req, store_req;
    logic [63:0] ifetch_addr, load_addr, store_addr, store_wdata;
    logic        store_wbeat_rdy;
    logic [2:0]  grant;
    logic [63:0] rdata;
    logic        rdata_valid;
    logic [2:0]  rbeat_idx;
    logic        ifetch_done, load_done, store_done;
    logic        bus_reqcyc;
    logic [63:0] bus_req_addr;
    logic        bus_req_write, bus_reqack, bus_wvalid;
    logic [63:0] bus_wdata;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic        bus_respack;

`ifdef MEMARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_rd_q[$];
    logic [2:0]  exp_idx_q[$];
    logic [63:0] exp_wd_q[$];
    logic [2:0]  exp_done_q[$];
    logic [2:0]  cur_own = 3'b000;
    logic [2:0]  dones_s;
    logic        any_out_s;

    assign dones_s   = {store_done, load_done, ifetch_done};
    assign any_out_s = |{store_wbeat_rdy, grant, rdata, rdata_valid, rbeat_idx, dones_s,
                         bus_reqcyc, bus_req_addr, bus_req_write, bus_wvalid, bus_wdata, bus_respack};

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr),
        .load_req(load_req), .load_addr(load_addr),
        .store_req(store_req), .store_addr(store_addr),
        .store_wdata(store_wdata), .store_wbeat_rdy(store_wbeat_rdy),
        .grant(grant), .rdata(rdata), .rdata_valid(rdata_valid), .rbeat_idx(rbeat_idx),
        .ifetch_done(ifetch_done), .load_done(load_done), .store_done(store_done),
        .bus_reqcyc(bus_reqcyc), .bus_req_addr(bus_req_addr), .bus_req_write(bus_req_write),
        .bus_reqack(bus_reqack), .bus_wvalid(bus_wvalid), .bus_wdata(bus_wdata),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_respack(bus_respack)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every observed beat/done must match the next expectation pushed by the driver.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rdata_valid) begin
                if (exp_rd_q.size() == 0) begin
                    check_eq("rd_spurious", 64'(rdata_valid), 64'h0);
                end else begin
                    check_eq("rdata", rdata, exp_rd_q.pop_front());
                    check_eq("rbeat_idx", 64'(rbeat_idx), 64'(exp_idx_q.pop_front()));
                    check_eq("rd_grant", 64'(grant), 64'(cur_own));
                    check_eq("respack", 64'(bus_respack), 64'h1);
                end
            end
            if (bus_wvalid) begin
                if (exp_wd_q.size() == 0) begin
                    check_eq("wd_spurious", 64'(bus_wvalid), 64'h0);
                end else begin
                    check_eq("bus_wdata", bus_wdata, exp_wd_q.pop_front());
                end
            end
            if (dones_s != 3'b000) begin
                check_eq("done_onehot", 64'($onehot(dones_s)), 64'h1);
                if (exp_done_q.size() == 0) begin
                    check_eq("done_spurious", 64'(dones_s), 64'h0);
                end else begin
                    check_eq("done_who", 64'(dones_s), 64'(exp_done_q.pop_front()));
                end
            end
        end
    end

    // Acts as the bus for one transfer; returns in the done cycle.
    task automatic serve(input logic [2:0] own, input logic [63:0] addr, input int hold,
                         input int gap, input logic [63:0] base, output int waited);
        waited  = 0;
        cur_own = own;
        while (!bus_reqcyc && waited < 40) begin
            tick();
            waited++;
        end
        check_eq("reqcyc_seen", 64'(bus_reqcyc), 64'h1);
        if (!bus_reqcyc) return;
        check_eq("req_grant", 64'(grant), 64'(own));
        check_eq("req_addr", bus_req_addr, addr);
        check_eq("req_write", 64'(bus_req_write), 64'(own[2]));
        for (int i = 1; i < hold; i++) begin
            tick();
            check_eq("reqcyc_hold", 64'(bus_reqcyc), 64'h1);
        end
        bus_reqack = 1'b1;
        tick();
        bus_reqack = 1'b0;
        check_eq("reqcyc_drop", 64'(bus_reqcyc), 64'h0);
        for (int b = 0; b < 8; b++) begin
            if (own[2]) begin
                store_wdata = base + 64'(b);
                exp_wd_q.push_back(base + 64'(b));
                check_eq("wbeat_rdy", 64'(store_wbeat_rdy), 64'h1);
            end else begin
                bus_respcyc = 1'b1;
                bus_resp    = base + 64'(b);
                exp_rd_q.push_back(base + 64'(b));
                exp_idx_q.push_back(3'(b));
            end
            if (b == 7) exp_done_q.push_back(own);
            tick();
            bus_respcyc = 1'b0;
            if (!own[2] && b < 7) begin
                for (int g = 0; g < gap; g++) tick();
            end
        end
        check_eq("done_pulse", 64'(dones_s), 64'(own));
        check_eq("done_grant", 64'(grant), 64'(own));
        check_eq("wbeat_rdy_off", 64'(store_wbeat_rdy), 64'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  w;
        bit  fetch_served;
        logic [2:0] own;
        reset_n = 1'b0;
        {ifetch_req, load_req, store_req, bus_reqack, bus_respcyc} = 5'b0;
        ifetch_addr = 64'h0000_0000_0000_8000;
        load_addr   = 64'h0000_0000_0000_2000;
        store_addr  = 64'h0000_0000_0000_1000;
        store_wdata = 64'h0;
        bus_resp    = 64'h0;
        tick();
        tick();
        check_eq("reset_outputs", 64'(any_out_s), 64'h0);
        reset_n = 1'b1;
        tick();

        // Load alone, immediate ack, back-to-back beats.
        load_req = 1'b1;
        serve(3'b010, 64'h2000, 1, 0, 64'h10, w);
        check_eq("t1_req_latency", 64'(w), 64'h1);
        load_req = 1'b0;
        tick();
        check_eq("t1_idle_grant", 64'(grant), 64'h0);
        check_eq("t1_idle_done", 64'(dones_s), 64'h0);

        // Store line.
        store_req = 1'b1;
        serve(3'b100, 64'h1000, 1, 0, 64'hA0, w);
        store_req = 1'b0;
        tick();

        // All three at once: store, load, fetch.
        {ifetch_req, load_req, store_req} = 3'b111;
        serve(3'b100, 64'h1000, 1, 0, 64'hB0, w);
        store_req = 1'b0;
        serve(3'b010, 64'h2000, 1, 0, 64'hC0, w);
        load_req = 1'b0;
        serve(3'b001, 64'h8000, 1, 0, 64'hD0, w);
        ifetch_req = 1'b0;
        tick();

        // Delayed ack and gapped response beats.
        load_req = 1'b1;
        serve(3'b010, 64'h2000, 5, 2, 64'hE0, w);
        load_req = 1'b0;
        tick();

        // Fetch competing with a continuously held load.
        ifetch_req   = 1'b1;
        load_req     = 1'b1;
        fetch_served = 1'b0;
        for (int k = 0; k < 5; k++) begin
            own = (STARVE_ON && k == 4) ? 3'b001 : 3'b010;
            serve(own, own[0] ? 64'h8000 : 64'h2000, 1, 0, 64'h100 + 64'(k * 16), w);
            if (own[0]) begin
                ifetch_req   = 1'b0;
                fetch_served = 1'b1;
            end
        end
        load_req = 1'b0;
        if (!fetch_served) begin
            serve(3'b001, 64'h8000, 1, 0, 64'h200, w);
            ifetch_req = 1'b0;
        end
        tick();

        // Reset during beat 3 of a response, then a clean load.
        load_addr = 64'h6000;
        load_req  = 1'b1;
        cur_own   = 3'b010;
        tick();
        check_eq("t6_reqcyc", 64'(bus_reqcyc), 64'h1);
        bus_reqack = 1'b1;
        tick();
        bus_reqack = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bus_respcyc = 1'b1;
            bus_resp    = 64'h60 + 64'(b);
            exp_rd_q.push_back(64'h60 + 64'(b));
            exp_idx_q.push_back(3'(b));
            tick();
        end
        bus_resp = 64'h63;
        reset_n  = 1'b0;
        #1;
        check_eq("t6_reset_outputs", 64'(any_out_s), 64'h0);
        tick();
        tick();
        bus_respcyc = 1'b0;
        reset_n     = 1'b1;
        serve(3'b010, 64'h6000, 1, 0, 64'h70, w);
        check_eq("t6_req_latency", 64'(w), 64'h1);
        load_req = 1'b0;
        tick();
        tick();

        check_eq("rd_q_empty", 64'(exp_rd_q.size()), 64'h0);
        check_eq("wd_q_empty", 64'(exp_wd_q.size()), 64'h0);
        check_eq("done_q_empty", 64'(exp_done_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
